// File: rtl/packed_switch_sched.sv
// Switch-setting sequencer for a column of packed crossbar switches.
// Optional build macro PSW_SCHED_STALL_CNT_EN adds a saturating STALL_CNT output.
module packed_switch_sched #(
  parameter int NUM_SW  = 8,
  parameter int NUM_CFG = 16,
  parameter int BEAT_W  = 8,
  parameter int SW_LAT  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CFG_WE,
  input  logic [$clog2(NUM_CFG)-1:0] CFG_ADDR,
  input  logic [NUM_SW-1:0]          CFG_DATA,
  input  logic                       START,
  input  logic [$clog2(NUM_CFG)-1:0] CFG_BASE,
  input  logic [BEAT_W-1:0]          NUM_PATS,
  input  logic [BEAT_W-1:0]          NUM_BEATS,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [NUM_SW-1:0]          SWITCH_SET,
  output logic                       OUT_VALID,
  output logic                       BUSY,
  output logic                       DONE
`ifdef PSW_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                STALL_CNT
`endif
);

  localparam int AW = $clog2(NUM_CFG);
  localparam logic [SW_LAT-1:0] TAIL_MASK = ~(SW_LAT'(1) << (SW_LAT - 1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [NUM_SW-1:0]   pat_tbl [NUM_CFG];
  logic [AW-1:0]       pat_idx;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   pat_cnt;
  logic [BEAT_W-1:0]   beat_last;
  logic [BEAT_W-1:0]   pat_last;
  logic [SW_LAT-1:0]   dly;
  logic                accept;
  logic                beat_end;
  logic                done_c;

  assign IN_READY   = (state == RUN);
  assign accept     = IN_VALID && IN_READY;
  assign beat_end   = (beat_cnt == beat_last);
  assign SWITCH_SET = accept ? pat_tbl[pat_idx] : '0;
  assign OUT_VALID  = dly[SW_LAT-1];
  assign BUSY       = (state != IDLE);
  // Final beat is out when nothing else remains behind it in the delay line.
  assign done_c     = (state == DRAIN) && dly[SW_LAT-1] && ((dly & TAIL_MASK) == '0);
  assign DONE       = done_c;

  // Table is intentionally not reset and is frozen while a run is active.
  always_ff @(posedge CLK) begin
    if (CFG_WE && (state == IDLE))
      pat_tbl[CFG_ADDR] <= CFG_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      pat_idx   <= '0;
      beat_cnt  <= '0;
      pat_cnt   <= '0;
      beat_last <= '0;
      pat_last  <= '0;
      dly       <= '0;
    end else begin
      dly <= (dly << 1) | SW_LAT'(accept);
      case (state)
        IDLE: begin
          if (START) begin
            state     <= RUN;
            pat_idx   <= CFG_BASE;
            beat_cnt  <= '0;
            pat_cnt   <= '0;
            beat_last <= (NUM_BEATS == '0) ? '0 : NUM_BEATS - 1'b1;
            pat_last  <= (NUM_PATS == '0) ? '0 : NUM_PATS - 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_end) begin
              beat_cnt <= '0;
              pat_idx  <= pat_idx + 1'b1;
              pat_cnt  <= pat_cnt + 1'b1;
              if (pat_cnt == pat_last)
                state <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (done_c)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSW_SCHED_STALL_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      STALL_CNT <= '0;
    else if ((state == IDLE) && START)
      STALL_CNT <= '0;
    else if ((state == RUN) && !IN_VALID && (STALL_CNT != 16'hFFFF))
      STALL_CNT <= STALL_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_packed_switch_sched.sv
// Scoreboard bench for packed_switch_sched: stimulus pushes expected switch settings,
// a negedge monitor checks SWITCH_SET, OUT_VALID timing and DONE timing.
module tb_packed_switch_sched;
  localparam int SW_LAT = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CFG_WE;
  logic [3:0] CFG_ADDR;
  logic [7:0] CFG_DATA;
  logic       START;
  logic [3:0] CFG_BASE;
  logic [7:0] NUM_PATS;
  logic [7:0] NUM_BEATS;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] SWITCH_SET;
  logic       OUT_VALID;
  logic       BUSY;
  logic       DONE;
`ifdef PSW_SCHED_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  packed_switch_sched #(.NUM_SW(8), .NUM_CFG(16), .BEAT_W(8), .SW_LAT(SW_LAT)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .START(START), .CFG_BASE(CFG_BASE), .NUM_PATS(NUM_PATS), .NUM_BEATS(NUM_BEATS),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SWITCH_SET(SWITCH_SET),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE)
`ifdef PSW_SCHED_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  int exp_beats = 0;
  logic [7:0] swq[$];
  int ovq[$];
  int doneq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (!RST) begin
      if (IN_VALID && IN_READY) begin
        if (swq.size() == 0) chk("switch_set_unexpected_beat", 1, 0);
        else chk("switch_set", int'(SWITCH_SET), int'(swq.pop_front()));
        ovq.push_back(cyc + SW_LAT);
        acc_cnt++;
        if (acc_cnt == exp_beats) doneq.push_back(cyc + SW_LAT);
      end else if (IN_READY) begin
        chk("stall_switch_set", int'(SWITCH_SET), 0);
      end
      if (OUT_VALID) begin
        if (ovq.size() == 0) chk("out_valid_unexpected", 1, 0);
        else chk("out_valid_cycle", cyc, ovq.pop_front());
      end
      if (DONE) begin
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, doneq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    CFG_WE = 1'b1; CFG_ADDR = 4'(addr); CFG_DATA = 8'(data);
    step();
    CFG_WE = 1'b0;
  endtask

  // mode: 0 valid always, 1 valid on odd RUN cycles, 2 inject write+START, 3 reset after 3 beats
  task automatic run(input int base, input int np, input int nb, input int mode,
                     input int exp_n, output int rc);
    bit stop;
    exp_beats = exp_n; acc_cnt = 0; stop = 0;
    CFG_BASE = 4'(base); NUM_PATS = 8'(np); NUM_BEATS = 8'(nb);
    START = 1'b1;
    step();
    START = 1'b0;
    rc = 0;
    while (IN_READY && rc < 200 && !stop) begin
      if (mode == 3 && rc == 3) begin
        IN_VALID = 1'b0;
        RST = 1'b1;
        ovq.delete();
        stop = 1;
      end else begin
        IN_VALID = (mode == 1) ? (rc % 2 == 1) : 1'b1;
        if (mode == 2 && rc == 3) begin
          CFG_WE = 1'b1; CFG_ADDR = 4'd1; CFG_DATA = 8'h3C; START = 1'b1;
        end else begin
          CFG_WE = 1'b0; START = 1'b0;
        end
        step();
        rc++;
      end
    end
    IN_VALID = 1'b0; CFG_WE = 1'b0; START = 1'b0;
    if (mode != 3) begin
      for (int i = 0; i < 40 && BUSY; i++) step();
      if (BUSY) chk("timeout_waiting_idle", 1, 0);
      step();
    end
  endtask

  int rc;

  initial begin
    RST = 1'b1; CFG_WE = 0; CFG_ADDR = 0; CFG_DATA = 0; START = 0;
    CFG_BASE = 0; NUM_PATS = 0; NUM_BEATS = 0; IN_VALID = 0;
    @(negedge CLK);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_in_ready", int'(IN_READY), 0);
    chk("reset_out_valid", int'(OUT_VALID), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_switch_set", int'(SWITCH_SET), 0);
    step();
    RST = 1'b0;
    step();

    // Test 1: basic 4x2 run
    cfg_write(0, 8'h00); cfg_write(1, 8'hFF); cfg_write(2, 8'hA5); cfg_write(3, 8'h0F);
    foreach (swq[i]) ;
    swq.push_back(8'h00); swq.push_back(8'h00); swq.push_back(8'hFF); swq.push_back(8'hFF);
    swq.push_back(8'hA5); swq.push_back(8'hA5); swq.push_back(8'h0F); swq.push_back(8'h0F);
    run(0, 4, 2, 0, 8, rc);
    chk("t1_run_cycles", rc, 8);

    // Test 3: alternating IN_VALID
    swq.push_back(8'h00); swq.push_back(8'h00); swq.push_back(8'hFF); swq.push_back(8'hFF);
    swq.push_back(8'hA5); swq.push_back(8'hA5); swq.push_back(8'h0F); swq.push_back(8'h0F);
    run(0, 4, 2, 1, 8, rc);
    chk("t3_run_cycles", rc, 16);
`ifdef PSW_SCHED_STALL_CNT_EN
    chk("t3_stall_cnt", int'(STALL_CNT), 8);
`endif

    // Test 4: zero counts treated as one
    swq.push_back(8'hA5);
    run(2, 0, 0, 0, 1, rc);
    chk("t4_run_cycles", rc, 1);

    // Test 5: write and START during RUN ignored
    swq.push_back(8'h00); swq.push_back(8'h00); swq.push_back(8'hFF); swq.push_back(8'hFF);
    swq.push_back(8'hA5); swq.push_back(8'hA5); swq.push_back(8'h0F); swq.push_back(8'h0F);
    run(0, 4, 2, 2, 8, rc);
    chk("t5_run_cycles", rc, 8);
    chk("t5_not_restarted", int'(BUSY), 0);
    swq.push_back(8'hFF);
    run(1, 1, 1, 0, 1, rc);

    // Test 6: reset mid-run
    swq.push_back(8'hFF); swq.push_back(8'hFF); swq.push_back(8'hFF);
    run(1, 2, 8, 3, 16, rc);
    @(negedge CLK);
    chk("t6_busy", int'(BUSY), 0);
    chk("t6_out_valid", int'(OUT_VALID), 0);
    chk("t6_switch_set", int'(SWITCH_SET), 0);
    chk("t6_done", int'(DONE), 0);
    step();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) step();
    swq.push_back(8'hA5); swq.push_back(8'h0F);
    run(2, 2, 1, 0, 2, rc);

    // Test 2: base wrap 15 -> 0
    cfg_write(14, 8'h01); cfg_write(15, 8'h02); cfg_write(0, 8'h04); cfg_write(1, 8'h08);
    swq.push_back(8'h01); swq.push_back(8'h02); swq.push_back(8'h04); swq.push_back(8'h08);
    run(14, 4, 1, 0, 4, rc);
    chk("t2_run_cycles", rc, 4);

    for (int i = 0; i < 5; i++) step();
    chk("sw_queue_empty", swq.size(), 0);
    chk("out_valid_queue_empty", ovq.size(), 0);
    chk("done_queue_empty", doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
